// File: rtl/apb_master.sv
// apb_master: single-outstanding APB requester behind a valid/ready command port.
// Define APB_MASTER_TIMEOUT_EN to bound ACCESS wait states to TIMEOUT_CYCLES.
module apb_master #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              pclock,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [DATA_W-1:0] prdata
);

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] SETUP  = 2'b01;
  localparam logic [1:0] ACCESS = 2'b10;

  logic [1:0]        state_reg, state_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic              pwrite_reg, pwrite_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic              rsp_err_reg, rsp_err_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              accept;
  logic              timeout;

  // State is forced to IDLE asynchronously, so psel/penable drop without a clock edge.
  assign cmd_ready = rst & (state_reg == IDLE);
  assign accept    = cmd_valid & cmd_ready;
  assign psel      = (state_reg == SETUP) | (state_reg == ACCESS);
  assign penable   = (state_reg == ACCESS);
  assign pwrite    = pwrite_reg;
  assign paddr     = paddr_reg;
  assign pwdata    = pwdata_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_err   = rsp_err_reg;
  assign rsp_rdata = rsp_rdata_reg;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

  // Fires on the wait edge that brings the count to TIMEOUT_CYCLES.
  assign timeout = (state_reg == ACCESS) & ~pready &
                   (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wait_cnt_next = wait_cnt_reg;
    if (state_reg == SETUP) begin
      wait_cnt_next = '0;
    end else if ((state_reg == ACCESS) && !pready) begin
      wait_cnt_next = wait_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge pclock or negedge rst) begin
    if (!rst) begin
      wait_cnt_reg <= '0;
    end else begin
      wait_cnt_reg <= wait_cnt_next;
    end
  end
`else
  // No wait limit in this build: constant false for any legal TIMEOUT_CYCLES.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_next     = state_reg;
    paddr_next     = paddr_reg;
    pwrite_next    = pwrite_reg;
    pwdata_next    = pwdata_reg;
    rsp_valid_next = 1'b0;
    rsp_err_next   = rsp_err_reg;
    rsp_rdata_next = rsp_rdata_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next  = SETUP;
          paddr_next  = cmd_addr;
          pwrite_next = cmd_write;
          pwdata_next = cmd_write ? cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_next = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_err_next   = pslverr;
          rsp_rdata_next = pwrite_reg ? '0 : prdata;
        end else if (timeout) begin
          state_next     = IDLE;
          rsp_valid_next = 1'b1;
          rsp_err_next   = 1'b1;
          rsp_rdata_next = '0;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge pclock or negedge rst) begin
    if (!rst) begin
      state_reg     <= IDLE;
      paddr_reg     <= '0;
      pwrite_reg    <= 1'b0;
      pwdata_reg    <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_rdata_reg <= '0;
    end else begin
      state_reg     <= state_next;
      paddr_reg     <= paddr_next;
      pwrite_reg    <= pwrite_next;
      pwdata_reg    <= pwdata_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_rdata_reg <= rsp_rdata_next;
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: scoreboard-based bench for apb_master; timeout cases follow APB_MASTER_TIMEOUT_EN.
module tb_apb_master;

  localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } rsp_t;

  logic        pclock = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        psel, penable, pwrite;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic        pready = 1'b0;
  logic        pslverr = 1'b0;
  logic [31:0] prdata = '0;

  int   checks = 0;
  int   errors = 0;
  rsp_t exp_q[$];

  apb_master #(.ADDR_W(16), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .pclock   (pclock),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .paddr    (paddr),
    .pwdata   (pwdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .prdata   (prdata)
  );

  always #5 pclock = ~pclock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000");
    $fatal(1, "watchdog expired");
  end

  // One full transfer; expected response computed from the stimulus and queued.
  task automatic do_transfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                             input int nwait, input logic [31:0] rdata, input logic slverr,
                             input logic junk);
    rsp_t e, got;
    int   acc_exp, k;
    bit   tmo, seen;
    tmo     = TO_EN && (nwait >= TO);
    acc_exp = tmo ? TO : nwait + 1;
    e.err   = tmo ? 1'b1 : slverr;
    e.rdata = (tmo || wr) ? 32'h0 : rdata;
    @(negedge pclock);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL idle_ready addr=%h: got %b want 1", addr, cmd_ready);
    end
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata;
    exp_q.push_back(e);
    @(negedge pclock);
    checks++;
    if ({psel, penable, pwrite} !== {2'b10, wr}) begin
      errors++; $display("FAIL setup_ctrl addr=%h: got %b want %b", addr, {psel, penable, pwrite}, {2'b10, wr});
    end
    checks++;
    if (paddr !== addr || pwdata !== (wr ? wdata : 32'h0)) begin
      errors++; $display("FAIL setup_bus: got %h/%h want %h/%h", paddr, pwdata, addr, wr ? wdata : 32'h0);
    end
    cmd_valid = junk; cmd_write = ~wr; cmd_addr = ~addr; cmd_wdata = $urandom;
    k = 0; seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      @(negedge pclock);
      if (rsp_valid === 1'b1) begin
        seen = 1;
      end else begin
        checks++;
        if ({psel, penable, pwrite} !== {2'b11, wr} || paddr !== addr || pwdata !== (wr ? wdata : 32'h0)) begin
          errors++; $display("FAIL access_hold cyc=%0d: got %b %h want %b %h", k, {psel, penable, pwrite}, paddr, {2'b11, wr}, addr);
        end
        cmd_valid = junk && (k < acc_exp - 1);
        pready    = (k == nwait);
        prdata    = (k == nwait) ? rdata : $urandom;
        pslverr   = (k == nwait) ? slverr : 1'b1;
        k++;
      end
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL rsp_timeout addr=%h: got no rsp_valid want rsp_valid", addr);
      void'(exp_q.pop_front());
    end else begin
      checks++;
      if (k !== acc_exp) begin
        errors++; $display("FAIL access_len addr=%h: got %0d want %0d", addr, k, acc_exp);
      end
      checks++;
      if ({psel, penable, cmd_ready} !== 3'b001) begin
        errors++; $display("FAIL rsp_ctrl: got %b want 001", {psel, penable, cmd_ready});
      end
      got = {rsp_err, rsp_rdata};
      e   = exp_q.pop_front();
      checks++;
      if (got !== e) begin
        errors++; $display("FAIL rsp_data addr=%h: got err=%b rdata=%h want err=%b rdata=%h", addr, got.err, got.rdata, e.err, e.rdata);
      end
    end
    pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
    $display("xfer wr=%0d addr=%h wdata=%h waits=%0d -> err=%b rdata=%h", wr, addr, wdata, nwait, rsp_err, rsp_rdata);
    @(negedge pclock);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== e.rdata) begin
      errors++; $display("FAIL rsp_pulse: got v=%b rdata=%h want v=0 rdata=%h", rsp_valid, rsp_rdata, e.rdata);
    end
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h1234; cmd_wdata = 32'hFFFF_FFFF;
    @(negedge pclock);
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 000000", {psel, penable, pwrite, rsp_valid, rsp_err, cmd_ready});
    end
    checks++;
    if (paddr !== 16'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_data: got %h/%h/%h want 0/0/0", paddr, pwdata, rsp_rdata);
    end
    cmd_valid = 1'b0;
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    end
    $display("reset released");
  endtask

  task automatic test_write();
    do_transfer(1'b1, 16'h0010, 32'hDEADBEEF, 0, 32'hA5A5A5A5, 1'b0, 1'b0);
  endtask

  task automatic test_read_wait();
    do_transfer(1'b0, 16'h0020, 32'h0, 3, 32'h12345678, 1'b0, 1'b1);
  endtask

  task automatic test_error();
    do_transfer(1'b0, 16'h0030, 32'h0, 0, 32'hCAFEF00D, 1'b1, 1'b0);
    do_transfer(1'b1, 16'h0034, 32'h0BAD0BAD, 1, 32'h77777777, 1'b1, 1'b1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] psel_exp = 8'b0011_0110;
    logic [7:0] pen_exp  = 8'b0010_0100;
    logic [7:0] rsp_exp  = 8'b0100_1000;
    rsp_t e, got;
    for (int c = 0; c < 8; c++) begin
      @(negedge pclock);
      checks++;
      if ({psel, penable, rsp_valid} !== {psel_exp[c], pen_exp[c], rsp_exp[c]}) begin
        errors++; $display("FAIL b2b_cyc%0d: got %b want %b", c, {psel, penable, rsp_valid}, {psel_exp[c], pen_exp[c], rsp_exp[c]});
      end
      if (rsp_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got = {rsp_err, rsp_rdata};
        checks++;
        if (got !== e) begin
          errors++; $display("FAIL b2b_rsp%0d: got %b/%h want %b/%h", c, got.err, got.rdata, e.err, e.rdata);
        end
        $display("b2b rsp cyc=%0d err=%b rdata=%h", c, rsp_err, rsp_rdata);
      end
      case (c)
        0: begin
          cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0100; cmd_wdata = 32'h11112222;
          exp_q.push_back('{err: 1'b0, rdata: 32'h0});
        end
        1: begin
          checks++;
          if (paddr !== 16'h0100 || pwrite !== 1'b1 || pwdata !== 32'h11112222) begin
            errors++; $display("FAIL b2b_first_bus: got %h/%b/%h want 0100/1/11112222", paddr, pwrite, pwdata);
          end
          cmd_write = 1'b0; cmd_addr = 16'h0104; cmd_wdata = 32'h33334444;
          exp_q.push_back('{err: 1'b0, rdata: 32'h0BADBEEF});
        end
        2: begin pready = 1'b1; prdata = 32'h55AA55AA; end
        3: begin pready = 1'b0; end
        4: begin
          cmd_valid = 1'b0;
          checks++;
          if (paddr !== 16'h0104 || pwrite !== 1'b0 || pwdata !== 32'h0) begin
            errors++; $display("FAIL b2b_second_bus: got %h/%b/%h want 0104/0/0", paddr, pwrite, pwdata);
          end
        end
        5: begin pready = 1'b1; prdata = 32'h0BADBEEF; end
        default: begin pready = 1'b0; end
      endcase
    end
  endtask

  task automatic test_reset_in_access();
    @(negedge pclock);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0040; cmd_wdata = 32'h99998888;
    @(negedge pclock);
    cmd_valid = 1'b0;
    @(negedge pclock);
    pready = 1'b0;
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++; $display("FAIL rst_pre_access: got %b want 11", {psel, penable});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({psel, penable, cmd_ready, rsp_valid} !== 4'b0000) begin
      errors++; $display("FAIL rst_async_drop: got %b want 0000", {psel, penable, cmd_ready, rsp_valid});
    end
    @(negedge pclock);
    checks++;
    if (paddr !== 16'h0 || pwdata !== 32'h0 || pwrite !== 1'b0) begin
      errors++; $display("FAIL rst_bus_clear: got %h/%h/%b want 0/0/0", paddr, pwdata, pwrite);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      errors++; $display("FAIL rst_release: got ready=%b psel=%b want 1/0", cmd_ready, psel);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge pclock);
      checks++;
      if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
        errors++; $display("FAIL rst_no_rsp cyc%0d: got v=%b psel=%b want 0/0", c, rsp_valid, psel);
      end
    end
    $display("reset during ACCESS aborted transfer");
  endtask

  task automatic test_wait_limit();
    do_transfer(1'b0, 16'h0050, 32'h0, 20, 32'h87654321, 1'b0, 1'b1);
    do_transfer(1'b1, 16'h0054, 32'h13572468, TO, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 6; i++) begin
      do_transfer(1'($urandom_range(0, 1)), 16'($urandom), $urandom, int'($urandom_range(0, 3)),
                  $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_wait();
    test_error();
    test_back_to_back();
    test_reset_in_access();
    test_wait_limit();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter ADDR_W, default 16, width of the APB and command address.
REQ-002 Parameter DATA_W, default 32, width of the APB and command data.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, maximum ACCESS wait cycles; used only when APB_MASTER_TIMEOUT_EN is defined.
REQ-004 pclock  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 cmd_valid  input  1  command request from the local side.
REQ-007 cmd_ready  output  1  block can accept a command.
REQ-008 cmd_write  input  1  1 = write, 0 = read.
REQ-009 cmd_addr  input  ADDR_W  command address.
REQ-010 cmd_wdata  input  DATA_W  write data.
REQ-011 rsp_valid  output  1  one-cycle completion pulse.
REQ-012 rsp_rdata  output  DATA_W  read data, valid with rsp_valid.
REQ-013 rsp_err  output  1  transfer error, valid with rsp_valid.
REQ-014 psel, penable, pwrite  output  1 each  APB requester controls.
REQ-015 paddr  output  ADDR_W  APB address.
REQ-016 pwdata  output  DATA_W  APB write data.
REQ-017 pready, pslverr  input  1 each  APB completer status.
REQ-018 prdata  input  DATA_W  APB read data.

Function
REQ-019 FSM states SHALL be IDLE, SETUP and ACCESS; encodings beyond these three SHALL return to IDLE.
REQ-020 cmd_ready SHALL be 1 only in IDLE; a command is accepted on a rising edge where cmd_valid and cmd_ready are both 1.
REQ-021 On acceptance the block SHALL register cmd_addr into paddr, cmd_write into pwrite, and cmd_wdata into pwdata for writes (0 for reads), then enter SETUP.
REQ-022 SETUP: psel=1, penable=0; the block SHALL unconditionally enter ACCESS after one cycle.
REQ-023 ACCESS: psel=1, penable=1; paddr, pwrite and pwdata SHALL hold stable until the transfer ends.
REQ-024 In ACCESS with pready=0 at an edge, the block SHALL remain in ACCESS (wait state).
REQ-025 In ACCESS with pready=1 at an edge, the block SHALL enter IDLE and, in the following cycle, drive rsp_valid=1 with rsp_err=pslverr sampled at that edge.
REQ-026 rsp_rdata SHALL take prdata sampled at the completing edge for reads and 0 for writes, and SHALL hold that value until the next response.
REQ-027 Latency: for a command accepted at edge N with pready=1 on first ACCESS, SETUP is cycle N+1, ACCESS is cycle N+2, and rsp_valid is high in cycle N+3.
REQ-028 Minimum issue interval SHALL be 3 cycles; in the rsp_valid cycle cmd_ready=1, so the next command may be accepted at that edge.
REQ-029 psel and penable SHALL be 0 in IDLE; penable SHALL never be 1 without psel.
REQ-030 cmd_* inputs SHALL be ignored outside IDLE.

Reset
REQ-031 On rst=0 the block SHALL immediately enter IDLE, independent of pclock, with psel=penable=pwrite=0, paddr=pwdata=0, rsp_valid=rsp_err=0, rsp_rdata=0, cmd_ready=0 while rst=0.
REQ-032 Reset during SETUP or ACCESS SHALL abort the transfer with no response pulse; the first cycle after release SHALL be IDLE with cmd_ready=1.

Configuration
REQ-033 When APB_MASTER_TIMEOUT_EN is defined, a wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with pready=0.
REQ-034 With APB_MASTER_TIMEOUT_EN, when the counter reaches TIMEOUT_CYCLES with pready still 0, the block SHALL enter IDLE and pulse rsp_valid with rsp_err=1 and rsp_rdata=0; if pready=1 on that same edge, normal completion takes priority.
REQ-035 Without APB_MASTER_TIMEOUT_EN, no counter SHALL exist and ACCESS SHALL wait for pready indefinitely.

Verification
REQ-036 Write: cmd_addr=0x0010, wdata=0xDEADBEEF, pready=1 -> psel high 2 cycles, penable high in cycle 2, pwrite=1, rsp_valid in cycle N+3 with rsp_err=0 and rsp_rdata=0.
REQ-037 Read with 3 wait states: pready low for 3 ACCESS cycles, then prdata=0x12345678 -> ACCESS lasts 4 cycles and rsp_rdata=0x12345678.
REQ-038 Error: read with pslverr=1 and pready=1 -> rsp_valid with rsp_err=1.
REQ-039 Back-to-back: cmd_valid held high for 2 commands -> second SETUP starts exactly 3 cycles after the first, and psel is 0 for one cycle between them.
REQ-040 Reset asserted during ACCESS -> psel and penable drop without a clock edge; no rsp_valid; cmd_ready=1 in the first cycle after release.
REQ-041 With APB_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES=4, pready held 0 -> after 4 wait edges rsp_valid=1, rsp_err=1, psel=0.
